// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// One outstanding imem request, a one-entry fetch buffer, and redirect/stall/flush handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] fb_instr, fb_pc;
    logic        fb_valid;
    logic        fb_take;
    logic        fill;

    assign fb_take   = fb_valid & ~StallD & ~FlushD & ~PCSrcE;
    assign fill      = (state == WAIT) & imem_valid & ~PCSrcE;
    assign imem_addr = PCF;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        imem_req  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rst && !StallF && !PCSrcE && (!fb_valid || fb_take)) begin
                    imem_req  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response coincident with a redirect is simply dropped here.
                if (imem_valid)  state_nxt = IDLE;
                else if (PCSrcE) state_nxt = DROP;
            end
            DROP: begin
                if (imem_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state    <= IDLE;
            PCF      <= RESET_PC;
            fb_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (PCSrcE) begin
                PCF      <= {PCTargetE[31:2], 2'b00};
                fb_valid <= 1'b0;
            end else if (fill) begin
                PCF      <= PCF + 32'd4;
                fb_valid <= 1'b1;
            end else if (fb_take) begin
                fb_valid <= 1'b0;
            end
        end
    end

    // NOTE: buffer payload is qualified by fb_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            fb_instr <= imem_rdata;
            fb_pc    <= PCF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (FlushD || PCSrcE) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (fb_valid) begin
                InstrD   <= fb_instr;
                PCD      <= fb_pc;
                PCPlus4D <= fb_pc + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule
